// File: rtl/loop_predictor_table.sv
`default_nettype none
// ============================================================================
//  Module      : loop_predictor_table
//  Description : Fetch-side loop predictor. Learns trip counts of backward
//                branches resolved in EX and predicts them once trusted.
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_predictor_table #(
    parameter int ENTRIES    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 10,
    parameter int CONF_WIDTH = 2,
    parameter int PIPE_DIST  = 1
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  loop_hit,
    output logic                  loop_confident,
    output logic                  loop_predict_taken,
    input  logic                  branch_ex,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  backward_ex,
    input  logic                  taken_ex,
    input  logic                  loop_flush
);

    localparam int                  C_RR_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [CNT_WIDTH:0]  C_PIPE    = (CNT_WIDTH+1)'(PIPE_DIST);
    localparam logic [C_RR_W-1:0]   C_RR_LAST = C_RR_W'(ENTRIES-1);

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [ENTRIES-1:0]    ovf_q,   ovf_d;
    logic [ADDR_WIDTH-1:0] tag_q  [ENTRIES];
    logic [ADDR_WIDTH-1:0] tag_d  [ENTRIES];
    logic [CNT_WIDTH-1:0]  trip_q [ENTRIES];
    logic [CNT_WIDTH-1:0]  trip_d [ENTRIES];
    logic [CNT_WIDTH-1:0]  iter_q [ENTRIES];
    logic [CNT_WIDTH-1:0]  iter_d [ENTRIES];
    logic [CONF_WIDTH-1:0] conf_q [ENTRIES];
    logic [CONF_WIDTH-1:0] conf_d [ENTRIES];
    logic [C_RR_W-1:0]     rr_q,    rr_d;

    logic              w_hit;
    logic [C_RR_W-1:0] w_hit_idx;
    logic              w_ex_hit;
    logic [C_RR_W-1:0] w_ex_idx;

    // Tags are unique, so at most one entry can match either port.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_ex_hit  = 1'b0;
        w_ex_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == pc)) begin
                w_hit     = 1'b1;
                w_hit_idx = C_RR_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == pc_ex)) begin
                w_ex_hit = 1'b1;
                w_ex_idx = C_RR_W'(i);
            end
        end
    end

    assign loop_hit           = w_hit;
    assign loop_confident     = w_hit && (&conf_q[w_hit_idx]);
    assign loop_predict_taken = loop_confident &&
                                (({1'b0, iter_q[w_hit_idx]} + C_PIPE) < {1'b0, trip_q[w_hit_idx]});

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        tag_d   = tag_q;
        trip_d  = trip_q;
        iter_d  = iter_q;
        conf_d  = conf_q;
        rr_d    = rr_q;
        if (loop_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
                ovf_d[i]   = 1'b0;
                iter_d[i]  = '0;
                conf_d[i]  = '0;
            end
            rr_d = '0;
        end else if (branch_ex) begin
            if (w_ex_hit) begin
                if (taken_ex) begin
                    // Once overflowed the iteration count is meaningless; pin it.
                    if (!ovf_q[w_ex_idx]) begin
                        if (&iter_q[w_ex_idx]) begin
                            ovf_d[w_ex_idx] = 1'b1;
                        end else begin
                            iter_d[w_ex_idx] = iter_q[w_ex_idx] + 1'b1;
                        end
                    end
                end else begin
                    if (ovf_q[w_ex_idx]) begin
                        valid_d[w_ex_idx] = 1'b0;
                    end else if (iter_q[w_ex_idx] == trip_q[w_ex_idx]) begin
                        if (!(&conf_q[w_ex_idx])) begin
                            conf_d[w_ex_idx] = conf_q[w_ex_idx] + 1'b1;
                        end
                    end else begin
                        trip_d[w_ex_idx] = iter_q[w_ex_idx];
                        conf_d[w_ex_idx] = '0;
                    end
                    iter_d[w_ex_idx] = '0;
                    ovf_d[w_ex_idx]  = 1'b0;
                end
            end else if (backward_ex && taken_ex) begin
                valid_d[rr_q] = 1'b1;
                tag_d[rr_q]   = pc_ex;
                iter_d[rr_q]  = CNT_WIDTH'(1);
                trip_d[rr_q]  = '0;
                conf_d[rr_q]  = '0;
                ovf_d[rr_q]   = 1'b0;
                rr_d          = (rr_q == C_RR_LAST) ? '0 : rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            valid_q <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                trip_q[i] <= '0;
                iter_q[i] <= '0;
                conf_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            tag_q   <= tag_d;
            trip_q  <= trip_d;
            iter_q  <= iter_d;
            conf_q  <= conf_d;
        end
    end

endmodule
`default_nettype wire
